packet_framer: RTL and testbench

PACKET_FRAMER -- requirements
Module: packet_framer

---
 rtl/packet_framer.sv | 126 ++++++++++++
 tb/tb_packet_framer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_framer.sv
// rtl/packet_framer.sv - packs a length-prefixed byte stream into 32-bit words, MSB lane first
module packet_framer #(
  parameter int MIN_LEN = 8
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [7:0]  byteIn,
  input  logic        byteIn_val,
  output logic        byteIn_ready,
  output logic [31:0] dataOut,
  output logic        dataOut_val,
  input  logic        dataOut_ready,
  output logic        dataOut_last,
  output logic        lenError
);

  typedef enum logic [1:0] {S_LEN0, S_LEN1, S_BODY} state_t;

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] out_q, out_d;
  logic        out_val_q, out_val_d;
  logic        out_last_q, out_last_d;
  logic        len_err_q, len_err_d;

  logic        accept;
  logic        last_byte;
  logic [15:0] raw_len;
  logic [31:0] word_now;

  assign byteIn_ready = (!out_val_q || dataOut_ready) && !reset_b;
  assign accept       = byteIn_val && byteIn_ready;
  // byte 0 still sits in the top lane of the assembly register while byte 1 arrives
  assign raw_len      = {byteIn, asm_q[31:24]};
  assign last_byte    = (state_q == S_BODY) && (cnt_q == len_q - 16'd1);

  assign dataOut      = out_q;
  assign dataOut_val  = out_val_q;
  assign dataOut_last = out_last_q;
  assign lenError     = len_err_q;

  // Unfilled lanes stay zero because the assembly register clears at each word boundary
  always_comb begin
    word_now = asm_q;
    case (cnt_q[1:0])
      2'd0:    word_now[31:24] = byteIn;
      2'd1:    word_now[23:16] = byteIn;
      2'd2:    word_now[15:8]  = byteIn;
      default: word_now[7:0]   = byteIn;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    out_d      = out_q;
    out_val_d  = out_val_q;
    out_last_d = out_last_q;
    len_err_d  = 1'b0;

    if (out_val_q && dataOut_ready) begin
      out_val_d  = 1'b0;
      out_last_d = 1'b0;
    end

    if (accept) begin
      asm_d = word_now;
      cnt_d = cnt_q + 16'd1;
      case (state_q)
        S_LEN0: state_d = S_LEN1;
        S_LEN1: begin
          state_d = S_BODY;
          if (raw_len < MIN_LEN_W) begin
            len_d     = MIN_LEN_W;
            len_err_d = 1'b1;
          end else begin
            len_d = raw_len;
          end
        end
        S_BODY: begin
          if (last_byte) begin
            state_d = S_LEN0;
            cnt_d   = 16'd0;
          end
        end
        default: state_d = S_LEN0;
      endcase

      if (cnt_q[1:0] == 2'd3 || last_byte) begin
        out_d      = word_now;
        out_val_d  = 1'b1;
        out_last_d = last_byte;
        asm_d      = 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q    <= S_LEN0;
      cnt_q      <= 16'd0;
      len_q      <= 16'd0;
      asm_q      <= 32'd0;
      out_q      <= 32'd0;
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      out_q      <= out_d;
      out_val_q  <= out_val_d;
      out_last_q <= out_last_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// tb/tb_packet_framer.sv - randomized and directed bench for packet_framer against a byte-queue model
module tb_packet_framer;

  localparam int MIN_LEN = 8;

  logic        clk = 1'b0;
  logic        reset_b = 1'b1;
  logic [7:0]  byteIn = 8'd0;
  logic        byteIn_val = 1'b0;
  logic        byteIn_ready;
  logic [31:0] dataOut;
  logic        dataOut_val;
  logic        dataOut_ready = 1'b0;
  logic        dataOut_last;
  logic        lenError;

  packet_framer #(.MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .reset_b(reset_b), .byteIn(byteIn), .byteIn_val(byteIn_val),
    .byteIn_ready(byteIn_ready), .dataOut(dataOut), .dataOut_val(dataOut_val),
    .dataOut_ready(dataOut_ready), .dataOut_last(dataOut_last), .lenError(lenError)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the packet's accepted bytes and forms words from them arithmetically
  logic [7:0]  mbytes[$];
  bit          mvalid = 0, mlast = 0, mlenerr = 0;
  logic [31:0] mword = 32'd0;
  int          meff = MIN_LEN;

  always @(posedge clk) begin
    bit macc, mfinal;
    int mcount, raw, base;
    logic [31:0] w;
    if (reset_b) begin
      mvalid = 0; mlast = 0; mlenerr = 0; mword = 32'd0; mbytes.delete();
    end else begin
      macc = byteIn_val && (!mvalid || dataOut_ready);
      mlenerr = 0;
      if (mvalid && dataOut_ready) begin mvalid = 0; mlast = 0; end
      if (macc) begin
        mbytes.push_back(byteIn);
        mcount = mbytes.size();
        if (mcount == 2) begin
          raw = {mbytes[1], mbytes[0]};
          mlenerr = (raw < MIN_LEN);
          meff = mlenerr ? MIN_LEN : raw;
        end
        mfinal = (mcount > 2) && (mcount == meff);
        if (mcount % 4 == 0 || mfinal) begin
          base = ((mcount - 1) / 4) * 4;
          w = 32'd0;
          for (int k = 0; k < 4; k++)
            if (base + k < mcount) w[31-8*k -: 8] = mbytes[base+k];
          mvalid = 1; mword = w; mlast = mfinal;
        end
        if (mfinal) mbytes.delete();
      end
    end
  end

  // Compare process, plus capture of transferred words for the literal checks
  logic [32:0] got[$];
  int          lenerr_seen = 0;
  bit          prev_stall = 0, prev_last = 0;
  logic [31:0] prev_data = 32'd0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byteIn_ready", 32'(byteIn_ready), 32'(!reset_b && (!mvalid || dataOut_ready)));
      chk("dataOut_val", 32'(dataOut_val), 32'(mvalid));
      chk("dataOut", dataOut, mword);
      chk("dataOut_last", 32'(dataOut_last), 32'(mlast));
      chk("lenError", 32'(lenError), 32'(mlenerr));
      if (prev_stall && !reset_b) begin
        chk("stall_data", dataOut, prev_data);
        chk("stall_val", 32'(dataOut_val), 32'd1);
        chk("stall_last", 32'(dataOut_last), 32'(prev_last));
      end
      if (lenError) lenerr_seen++;
      if (dataOut_val && dataOut_ready && !reset_b) got.push_back({dataOut_last, dataOut});
      prev_stall = dataOut_val && !dataOut_ready && !reset_b;
      prev_data  = dataOut;
      prev_last  = dataOut_last;
    end
  end

  int val_pct = 100, rdy_pct = 100, stall = 0, attempts = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    int guard = 0;
    byteIn = b;
    do begin
      byteIn_val = ($urandom_range(99) < val_pct);
      dataOut_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (stall > 0) stall--;
      attempts++;
      @(negedge clk);
      acc = byteIn_val && byteIn_ready;
      step();
      guard++;
    end while (!acc && guard < 1000);
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    byteIn_val = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) push_byte(q[i]);
  endtask

  task automatic drain();
    int guard = 0;
    byteIn_val = 1'b0;
    dataOut_ready = 1'b1;
    step();
    while (dataOut_val && guard < 100) begin step(); guard++; end
    if (dataOut_val) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_b = 1'b1;
    byteIn_val = 1'b0;
    step();
    chk_en = 1;
    step();
    reset_b = 1'b0;
  endtask

  function automatic void make_pkt(input int len_field, input int nbytes, output logic [7:0] q[$]);
    q.delete();
    q.push_back(8'(len_field));
    q.push_back(8'(len_field >> 8));
    for (int i = 2; i < nbytes; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] q[$];
    int lf, eff, cut;

    do_reset();
    chk("reset_val", 32'(dataOut_val), 32'd0);
    chk("reset_data", dataOut, 32'd0);

    // 20-byte packet with known header and ramp payload
    q = '{8'h14, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 12; i++) q.push_back(8'(8'hA0 + i));
    got.delete();
    send_q(q);
    drain();
    chk("p20_words", got.size(), 32'd5);
    if (got.size() == 5) begin
      chk("p20_w0", got[0][31:0], 32'h14000C00);
      chk("p20_w1", got[1][31:0], 32'h01000000);
      chk("p20_w4", got[4][31:0], 32'hA8A9AAAB);
      for (int i = 0; i < 5; i++) chk("p20_last", 32'(got[i][32]), 32'(i == 4));
    end

    // length 25: one real byte in the final word
    make_pkt(25, 25, q);
    q[24] = 8'h5A;
    got.delete();
    send_q(q);
    drain();
    chk("p25_words", got.size(), 32'd7);
    if (got.size() == 7) chk("p25_w6", got[6], {1'b1, 32'h5A000000});

    // short length field: framed with MIN_LEN, then a normal packet follows
    got.delete();
    lenerr_seen = 0;
    q = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_q(q);
    drain();
    chk("short_lenerr", lenerr_seen, 32'd1);
    chk("short_words", got.size(), 32'd2);
    if (got.size() == 2) chk("short_w1", got[1], {1'b1, 32'h33445566});
    q = '{8'h08, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send_q(q);
    drain();
    chk("after_short_words", got.size(), 32'd4);
    if (got.size() == 4) chk("after_short_w2", got[2], {1'b0, 32'h0800C1C2});
    chk("after_short_lenerr", lenerr_seen, 32'd1);

    // downstream stall of 10 cycles mid-packet
    got.delete();
    make_pkt(20, 20, q);
    for (int i = 0; i < 20; i++) begin
      if (i == 6) stall = 10;
      push_byte(q[i]);
    end
    drain();
    chk("stall_words", got.size(), 32'd5);
    if (got.size() == 5) chk("stall_w1", got[1][31:0], {q[4], q[5], q[6], q[7]});

    // reset mid-packet discards it; next packet starts at byte 0
    make_pkt(20, 10, q);
    send_q(q);
    do_reset();
    got.delete();
    q = '{8'h08, 8'h00, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_q(q);
    drain();
    chk("rst_words", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("rst_w0", got[0], {1'b0, 32'h08003344});
      chk("rst_w1", got[1], {1'b1, 32'h55667788});
    end

    // two back-to-back 20-byte packets at full rate
    got.delete();
    attempts = 0;
    make_pkt(20, 20, q);
    send_q(q);
    make_pkt(20, 20, q);
    send_q(q);
    drain();
    chk("b2b_cycles", attempts, 32'd40);
    chk("b2b_words", got.size(), 32'd10);
    if (got.size() == 10)
      for (int i = 0; i < 10; i++) chk("b2b_last", 32'(got[i][32]), 32'(i == 4 || i == 9));

    // randomized traffic with backpressure, short lengths and occasional resets
    val_pct = 70;
    rdy_pct = 60;
    for (int p = 0; p < 40; p++) begin
      lf  = $urandom_range(0, 48);
      eff = (lf < MIN_LEN) ? MIN_LEN : lf;
      cut = ($urandom_range(7) == 0) ? $urandom_range(1, eff - 1) : eff;
      make_pkt(lf, cut, q);
      send_q(q);
      if (cut != eff) do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
